core_sequencer: RTL and testbench

//  Multi-cycle sequencer for the single-issue RV32I core. Steps the FSM fetch->decode->execute->mem->writeback,
//  and shares one memory port between instruction fetch and load/store. Owns PC, instruction register (IR),

---
 rtl/core_pkg.sv | 27 ++
 rtl/seq_timeout_counter.sv | 29 ++
 rtl/core_sequencer.sv | 139 +++++++++++++
 tb/tb_core_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle RV32I sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_TRAP
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_MISALIGNED = 2'd0,
    CAUSE_TIMEOUT    = 2'd1,
    CAUSE_ILLEGAL    = 2'd2
  } trap_cause_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Jump/branch targets are halfword-granular; bit 0 is always dropped.
  function automatic logic [31:0] redirect_target(input logic [31:0] target);
    return {target[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Wait-cycle counter shared by the fetch and load/store memory waits.
module seq_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int unsigned    CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: reset is synchronous, so it lives inside the clocked branch like any other clear.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // hit flags the LIMIT-th consecutive waiting cycle; LIMIT of zero never fires.
  assign hit = (LIMIT != 0) && en && (cnt_q == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer sharing one memory port.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_illegal,
  input  logic        pc_redirect,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        rf_wen_in,
  output logic        rf_commit,
  output logic [31:0] mdr,
  output logic [31:0] retired,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  seq_state_t  state_q;
  trap_cause_t cause_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] mdr_q;
  logic [31:0] retired_q;
  logic        trap_q;

  logic fetch_aligned;
  logic in_fetch;
  logic in_mem;
  logic wait_clr;
  logic wait_en;
  logic wait_hit;

  // NOTE: every port-facing strobe is gated by rst_n so a reset edge drops a pending request at once.
  assign fetch_aligned = (pc_q[1:0] == 2'b00);
  assign in_fetch      = rst_n && (state_q == ST_FETCH) && fetch_aligned;
  assign in_mem        = rst_n && (state_q == ST_MEM);

  assign mem_req   = in_fetch || in_mem;
  assign mem_we    = in_mem && is_store;
  assign mem_addr  = in_mem ? alu_result : pc_q;
  assign mem_wdata = in_mem ? store_data : 32'h0;
  assign rf_commit = rst_n && (state_q == ST_WRITEBACK) && rf_wen_in && !is_store;

  // The counter idles cleared whenever no request is outstanding, so each wait starts from zero.
  assign wait_clr = !mem_req;
  assign wait_en  = mem_req && !mem_ready;

  seq_timeout_counter #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wait_clr),
    .en    (wait_en),
    .hit   (wait_hit)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= NOP_INSTR;
      mdr_q     <= 32'h0;
      retired_q <= 32'h0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_MISALIGNED;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_FETCH;
        ST_FETCH: begin
          if (!fetch_aligned) begin
            state_q <= ST_TRAP;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_MISALIGNED;
          end else if (mem_ready) begin
            ir_q    <= mem_rdata;
            state_q <= ST_DECODE;
          end else if (wait_hit) begin
            state_q <= ST_TRAP;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
          end
        end
        ST_DECODE: state_q <= ST_EXECUTE;
        ST_EXECUTE: begin
          if (is_illegal) begin
            state_q <= ST_TRAP;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_ILLEGAL;
          end else if (is_load || is_store) begin
            state_q <= ST_MEM;
          end else begin
            state_q <= ST_WRITEBACK;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (is_load) mdr_q <= mem_rdata;
            state_q <= ST_WRITEBACK;
          end else if (wait_hit) begin
            state_q <= ST_TRAP;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
          end
        end
        ST_WRITEBACK: begin
          pc_q      <= pc_redirect ? redirect_target(alu_result) : pc_q + 32'd4;
          retired_q <= retired_q + 32'd1;
          state_q   <= ST_FETCH;
        end
        ST_TRAP: state_q <= ST_TRAP;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr      = ir_q;
  assign pc         = pc_q;
  assign mdr        = mdr_q;
  assign retired    = retired_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench: a program-level reference model predicts every memory access, commit and trap.
module tb_core_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TO       = 4;
  localparam int          NEVER    = 99;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum {K_ALU, K_LOAD, K_STORE, K_JUMP, K_ILL} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic        wen;
    int          wf;
    int          wm;
  } op_t;
  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } acc_t;
  typedef struct { int cyc; logic [31:0] pc; logic [31:0] mdr; logic [31:0] ret; } cmt_t;
  typedef struct { int cyc; logic [1:0] cause; } trp_t;

  logic        clk, rst_n;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] instr, pc, alu_result, store_data, mdr, retired;
  logic        is_load, is_store, is_illegal, pc_redirect, rf_wen_in, rf_commit, trap;
  logic [1:0]  trap_cause;

  core_sequencer #(.RESET_PC(RESET_PC), .MEM_TIMEOUT(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .instr(instr), .pc(pc),
    .is_load(is_load), .is_store(is_store), .is_illegal(is_illegal), .pc_redirect(pc_redirect),
    .alu_result(alu_result), .store_data(store_data), .rf_wen_in(rf_wen_in), .rf_commit(rf_commit),
    .mdr(mdr), .retired(retired), .trap(trap), .trap_cause(trap_cause)
  );

  op_t         prog [64];
  int          prog_len = 0;
  logic [31:0] imem [logic [31:0]];
  acc_t        acc_q [$];
  cmt_t        cmt_q [$];
  trp_t        trp_q [$];
  int          wait_q [$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          trap_seen = 0;
  logic [31:0] exp_pc, exp_ret;
  logic [1:0]  exp_cause;

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] data_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic op_t mk(input kind_e k, input logic [31:0] a, input logic [31:0] sd,
                             input logic w, input int f, input int m);
    op_t o;
    o.kind = k; o.alu = a; o.sdata = sd; o.wen = w; o.wf = f; o.wm = m;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Program-level model: walks the instruction list using the per-state latency rules.
  task automatic build_model(input int start);
    logic [31:0] p, m, r;
    int s, t, wb;
    op_t o;
    imem.delete();
    p = RESET_PC; m = 32'h0; r = 32'h0; s = start; exp_cause = 2'd0;
    for (int i = 0; i < prog_len; i++) begin
      o = prog[i];
      if (p[1:0] != 2'b00) begin
        trp_q.push_back('{s + 1, 2'd0}); exp_cause = 2'd0; break;
      end
      imem[p] = {8'(i + 1), 24'h00_0013};
      if (o.wf >= NEVER) begin
        wait_q.push_back(NEVER); acc_q.push_back('{-1, 1'b0, p, 32'h0});
        trp_q.push_back('{s + TO, 2'd1}); exp_cause = 2'd1; break;
      end
      wait_q.push_back(o.wf);
      acc_q.push_back('{s + o.wf, 1'b0, p, 32'h0});
      t = s + o.wf;
      if (o.kind == K_ILL) begin
        trp_q.push_back('{t + 3, 2'd2}); exp_cause = 2'd2; break;
      end
      wb = t + 3;
      if (o.kind == K_LOAD || o.kind == K_STORE) begin
        if (o.wm >= NEVER) begin
          wait_q.push_back(NEVER); acc_q.push_back('{-1, o.kind == K_STORE, o.alu, o.sdata});
          trp_q.push_back('{t + 3 + TO, 2'd1}); exp_cause = 2'd1; break;
        end
        wait_q.push_back(o.wm);
        acc_q.push_back('{t + 3 + o.wm, o.kind == K_STORE, o.alu, o.sdata});
        if (o.kind == K_LOAD) m = data_word(o.alu);
        wb = t + 4 + o.wm;
      end
      if (o.wen && o.kind != K_STORE) cmt_q.push_back('{wb, p, m, r});
      r = r + 32'd1;
      p = (o.kind == K_JUMP) ? (o.alu & ~32'd1) : p + 32'd4;
      s = wb + 1;
    end
    exp_pc = p; exp_ret = r;
  endtask

  // Control-unit stand-in plus memory responder; ready noise is driven while no request is pending.
  initial begin : responder
    bit  busy;
    int  w, idx;
    op_t o;
    busy = 0; w = 0; mem_ready = 1'b0; mem_rdata = 32'h0;
    is_load = 0; is_store = 0; is_illegal = 0; pc_redirect = 0;
    alu_result = 32'h0; store_data = 32'h0; rf_wen_in = 0;
    forever begin
      @(negedge clk);
      idx = int'(instr[31:24]) - 1;
      if (instr[31:24] != 8'h00 && idx < prog_len) begin
        o = prog[idx];
        is_load = (o.kind == K_LOAD); is_store = (o.kind == K_STORE);
        is_illegal = (o.kind == K_ILL); pc_redirect = (o.kind == K_JUMP);
        alu_result = o.alu; store_data = o.sdata; rf_wen_in = o.wen;
      end else begin
        is_load = 0; is_store = 0; is_illegal = 0; pc_redirect = 0;
        alu_result = 32'h0; store_data = 32'h0; rf_wen_in = 0;
      end
      if (rst_n !== 1'b1) begin
        busy = 0; mem_ready = 1'b0;
        continue;
      end
      if (busy && mem_ready) busy = 0;
      if (mem_req && !busy) begin
        busy = 1;
        w = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
      end
      if (busy) begin
        if (w == 0) begin
          mem_ready = 1'b1;
          if (mem_we) mem_rdata = $urandom;
          else mem_rdata = imem.exists(mem_addr) ? imem[mem_addr] : data_word(mem_addr);
        end else begin
          mem_ready = 1'b0;
          w--;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  initial begin : monitor
    acc_t a;
    cmt_t c;
    trp_t t;
    forever begin
      @(negedge clk); #1;
      if (rst_n !== 1'b1) continue;
      if (mem_req) begin
        if (acc_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_req: addr %h we %b, none expected (cycle %0d)", mem_addr, mem_we, cyc);
        end else begin
          a = acc_q[0];
          check("req_addr", mem_addr, a.addr);
          check("req_we", 32'(mem_we), 32'(a.we));
          if (a.we) check("req_wdata", mem_wdata, a.wdata);
          if (mem_ready) begin
            check("req_done_cycle", 32'(cyc), 32'(a.cyc));
            a = acc_q.pop_front();
          end
        end
      end
      if (rf_commit) begin
        if (cmt_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_commit: pc %h, none expected (cycle %0d)", pc, cyc);
        end else begin
          c = cmt_q.pop_front();
          check("commit_cycle", 32'(cyc), 32'(c.cyc));
          check("commit_pc", pc, c.pc);
          check("commit_mdr", mdr, c.mdr);
          check("commit_retired", retired, c.ret);
        end
      end
      if (trap === 1'b1 && !trap_seen) begin
        trap_seen = 1;
        if (trp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_trap: cause %0d (cycle %0d)", trap_cause, cyc);
        end else begin
          t = trp_q.pop_front();
          check("trap_cycle", 32'(cyc), 32'(t.cyc));
          check("trap_cause_at_entry", 32'(trap_cause), 32'(t.cause));
          if (acc_q.size() > 0 && acc_q[0].cyc < 0) a = acc_q.pop_front();
        end
      end
      if (trap === 1'b1) check("trap_quiet", {30'h0, mem_req, rf_commit}, 32'h0);
    end
  end

  task automatic run_seg(input int abort_at);
    int start, budget;
    acc_q.delete(); cmt_q.delete(); trp_q.delete(); wait_q.delete(); trap_seen = 0;
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    check("rst_pc", pc, RESET_PC);
    check("rst_instr", instr, NOP);
    check("rst_mdr", mdr, 32'h0);
    check("rst_retired", retired, 32'h0);
    check("rst_trap", {30'h0, trap, rf_commit}, 32'h0);
    check("rst_cause", 32'(trap_cause), 32'h0);
    check("rst_req", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    start = cyc + 1;
    build_model(start);
    if (abort_at > 0) begin
      while (cyc < start + abort_at) @(posedge clk);
      #2 rst_n = 1'b0;
      acc_q.delete(); cmt_q.delete(); trp_q.delete(); wait_q.delete();
      @(posedge clk); @(negedge clk); #1;
      check("abort_req", {30'h0, mem_req, rf_commit}, 32'h0);
      check("abort_pc", pc, RESET_PC);
      check("abort_retired", retired, 32'h0);
      check("abort_trap", {31'h0, trap}, 32'h0);
      return;
    end
    budget = 0;
    while (!(trap_seen && cmt_q.size() == 0 && acc_q.size() == 0) && budget < 3000) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL seg_hang: trap_seen %0d, %0d accesses and %0d commits outstanding",
               trap_seen, acc_q.size(), cmt_q.size());
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("end_trap", {31'h0, trap}, 32'h1);
    check("end_cause", 32'(trap_cause), 32'(exp_cause));
    check("end_pc", pc, exp_pc);
    check("end_retired", retired, exp_ret);
    check("end_traps_drained", 32'(trp_q.size()), 32'h0);
  endtask

  task automatic gen_random(input int n);
    logic [31:0] p;
    kind_e k;
    int sel;
    p = RESET_PC;
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 9);
      k = (sel < 4) ? K_ALU : (sel < 6) ? K_LOAD : (sel < 8) ? K_STORE : K_JUMP;
      prog[i] = mk(k, 32'h8000_0000 | ($urandom & 32'h0000_FFFC), $urandom, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 3));
      if (k == K_JUMP) prog[i].alu = p + 32'(4 * $urandom_range(2, 16)) + 32'($urandom_range(0, 1));
      p = (k == K_JUMP) ? (prog[i].alu & ~32'd1) : p + 32'd4;
    end
    case ($urandom_range(0, 3))
      0:       prog[n] = mk(K_ILL, 32'h0, 32'h0, 1'b1, $urandom_range(0, 3), 0);
      1:       prog[n] = mk(K_JUMP, p + 32'd10, 32'h0, 1'b1, 0, 0);
      2:       prog[n] = mk(K_LOAD, 32'h8000_1000, 32'h0, 1'b1, 0, NEVER);
      default: prog[n] = mk(K_ALU, 32'h0, 32'h0, 1'b1, NEVER, 0);
    endcase
    prog[n + 1] = mk(K_ILL, 32'h0, 32'h0, 1'b0, 0, 0);
    prog_len = n + 2;
  endtask

  initial begin : stimulus
    rst_n = 1'b0;

    // Three ADDIs at zero wait, then an illegal op to park the core.
    for (int i = 0; i < 3; i++) prog[i] = mk(K_ALU, 32'h0, 32'h0, 1'b1, 0, 0);
    prog[3] = mk(K_ILL, 32'h0, 32'h0, 1'b1, 0, 0);
    prog_len = 4;
    run_seg(0);

    // LW with three wait cycles, SW with rf_wen set, JAL to 0x201, fetch ready on its fourth cycle, misaligned JAL.
    prog[0] = mk(K_LOAD,  32'h0000_0100, 32'h0,         1'b1, 0, 3);
    prog[1] = mk(K_STORE, 32'h8000_0040, 32'hDEAD_BEEF, 1'b1, 0, 1);
    prog[2] = mk(K_JUMP,  32'h0000_0201, 32'h0,         1'b1, 0, 0);
    prog[3] = mk(K_ALU,   32'h0,         32'h0,         1'b1, 3, 0);
    prog[4] = mk(K_JUMP,  32'h0000_0202, 32'h0,         1'b0, 0, 0);
    prog[5] = mk(K_ILL,   32'h0,         32'h0,         1'b0, 0, 0);
    prog_len = 6;
    run_seg(0);

    // Data-side timeout, then fetch-side timeout.
    prog[0] = mk(K_ALU,  32'h0, 32'h0, 1'b1, 0, 0);
    prog[1] = mk(K_LOAD, 32'h8000_0200, 32'h0, 1'b1, 1, NEVER);
    prog_len = 2;
    run_seg(0);
    prog[1] = mk(K_ALU, 32'h0, 32'h0, 1'b1, NEVER, 0);
    run_seg(0);

    // Reset lands on the second MEM wait cycle of a load.
    prog[1] = mk(K_LOAD, 32'h8000_0300, 32'h0, 1'b1, 0, NEVER);
    run_seg(8);

    for (int s = 0; s < 8; s++) begin
      gen_random(20);
      run_seg(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
